cv32e40p_x_result_buf: RTL

Buffers results returned on the x-interface result channel and retires them into the core register file. A result is written only in cycles when the core's own writeback stage is not using the register-file write port. On every retirement the block emits a scoreboard-clear strobe, which the x-interface dispatcher uses as its result-valid/result-address pair. It sits directly downstream of the coprocessor result channel and upstream of the dispatcher scoreboard and the register-file write port.

---
 rtl/cv32e40p_x_if_pkg.sv | 20 ++
 rtl/cv32e40p_x_result_buf_if.sv | 15 +
 rtl/cv32e40p_x_result_fifo.sv | 59 +++++
 rtl/cv32e40p_x_result_buf.sv | 78 +++++++
 4 files changed

// File: rtl/cv32e40p_x_if_pkg.sv
// Shared types for the x-interface result path: the buffered result entry
// and a helper that maps a register address to its pending bit.
package cv32e40p_x_if_pkg;

    localparam int XLEN = 32;

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
        logic            err;
    } x_result_entry_t;

    function automatic logic [31:0] rd_onehot(input logic [4:0] rd);
        logic [31:0] v;
        v     = '0;
        v[rd] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/cv32e40p_x_result_buf_if.sv
// Coprocessor result channel. A result transfers on a rising clock edge where
// valid and ready are both high; ready never depends on valid in the same cycle.
interface cv32e40p_x_result_buf_if #(
    parameter int XLEN = 32
);
    logic            valid;
    logic            ready;
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
    logic            we;
    logic            err;

    modport master (output valid, rd, data, we, err, input ready);
    modport slave  (input valid, rd, data, we, err, output ready);
endinterface

// File: rtl/cv32e40p_x_result_fifo.sv
// Circular result store with wrap-around pointers and an occupancy count.
// Exposes per-slot valid and rd so the owner can build a pending mask.
module cv32e40p_x_result_fifo
    import cv32e40p_x_if_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  push_i,
    input  x_result_entry_t       push_entry_i,
    input  logic                  pop_i,
    output x_result_entry_t       head_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [DEPTH-1:0]      entry_valid_o,
    output logic [DEPTH-1:0][4:0] entry_rd_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    x_result_entry_t r_mem [DEPTH];
    logic [AW-1:0]   r_rptr;
    logic [AW-1:0]   r_wptr;
    logic [CW-1:0]   r_count;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rptr  <= '0;
            r_wptr  <= '0;
            r_count <= '0;
        end else begin
            if (push_i) r_wptr <= r_wptr + AW'(1);
            if (pop_i)  r_rptr <= r_rptr + AW'(1);
            case ({push_i, pop_i})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) r_mem[r_wptr] <= push_entry_i;
    end

    assign head_o  = r_mem[r_rptr];
    assign full_o  = (r_count == CW'(DEPTH));
    assign empty_o = (r_count == '0);

    // A slot is live when its distance from the read pointer is below count.
    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        logic [AW-1:0] w_off;
        assign w_off            = AW'(i) - r_rptr;
        assign entry_valid_o[i] = ({1'b0, w_off} < r_count);
        assign entry_rd_o[i]    = r_mem[i].rd;
    end

endmodule

// File: rtl/cv32e40p_x_result_buf.sv
// Buffers coprocessor results and retires them into the register file in
// cycles the core writeback stage leaves the write port free.
module cv32e40p_x_result_buf
    import cv32e40p_x_if_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = cv32e40p_x_if_pkg::XLEN
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    cv32e40p_x_result_buf_if.slave    x_result,
    input  logic                      core_we_wb_i,
    output logic                      rf_we_o,
    output logic [4:0]                rf_waddr_o,
    output logic [XLEN-1:0]           rf_wdata_o,
    output logic                      sb_clr_valid_o,
    output logic [4:0]                sb_clr_addr_o,
    output logic                      err_o,
    output logic [31:0]               pending_o,
    output logic                      empty_o
);
    x_result_entry_t       w_push_entry;
    x_result_entry_t       w_head;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_accept;
    logic                  w_push;
    logic                  w_pop;
    logic [DEPTH-1:0]      w_entry_valid;
    logic [DEPTH-1:0][4:0] w_entry_rd;
    logic [31:0]           w_pending;

    assign x_result.ready = ~w_full & ~rst_i;
    assign w_accept       = x_result.valid & x_result.ready;
    // Results with neither a writeback nor an error have nothing to retire.
    assign w_push         = w_accept & (x_result.we | x_result.err);

    assign w_push_entry.rd   = x_result.rd;
    assign w_push_entry.data = x_result.data;
    assign w_push_entry.err  = x_result.err;

    // Errored entries skip the register file, so they never wait for the port.
    assign w_pop = ~w_empty & ~rst_i & (w_head.err | ~core_we_wb_i);

    cv32e40p_x_result_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .push_i        (w_push),
        .push_entry_i  (w_push_entry),
        .pop_i         (w_pop),
        .head_o        (w_head),
        .full_o        (w_full),
        .empty_o       (w_empty),
        .entry_valid_o (w_entry_valid),
        .entry_rd_o    (w_entry_rd)
    );

    assign rf_we_o        = w_pop & ~w_head.err & (w_head.rd != 5'd0);
    assign rf_waddr_o     = w_head.rd;
    assign rf_wdata_o     = w_head.data;
    assign sb_clr_valid_o = w_pop;
    assign sb_clr_addr_o  = w_head.rd;
    assign err_o          = w_pop & w_head.err;

    always_comb begin
        w_pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_entry_valid[i]) w_pending = w_pending | rd_onehot(w_entry_rd[i]);
        end
        w_pending[0] = 1'b0;
    end

    assign pending_o = rst_i ? 32'd0 : w_pending;
    assign empty_o   = w_empty | rst_i;

endmodule
